u109_pci_tack_sequencer: RTL and testbench
==========================================

// Module: u109_pci_tack_sequencer
// PURPOSE
//  Sequences each 68040-to-PCI transfer in U109. Qualifies TS against the PCI address decode.
//  Requests the PCI engine, then converts its per-word data events into the start/beat strobes
//  (PCI_TACK, BURST, rd_ready, wr_ready) that drive the cycle-termination block. That block
//  samples on the falling edge of CLK40. This block is rising-edge, so its strobes are stable
//  half a cycle before they are sampled. A watchdog also aborts hung PCI cycles.
// PARAMETERS
//  BEATS      4    longwords per line (burst) transfer; power of 2, 2..8
//  TIMEOUT    255  cycles without a data event before abort
//  TMO_W      8    watchdog counter width; must satisfy 2**TMO_W > TIMEOUT
// PORTS
//  CLK40           in   1  40 MHz CPU clock; all logic on its rising edge
//  RESET           in   1  synchronous, active-high reset
//  TS              in   1  transfer start, active-high, one cycle, already synchronised
//  RnW             in   1  1 = read, 0 = write; sampled with TS
//  SIZ             in   2  68040 size; 2'b11 = line (burst) transfer
//  PCI_HIT         in   1  address decodes to PCI space; sampled with TS
//  PCI_GNT         in   1  PCI engine accepts the request (level)
//  PCI_DATA_VLD    in   1  read word latched for the CPU (1-cycle pulse per word)
//  PCI_DATA_TAKEN  in   1  write word consumed by PCI (1-cycle pulse per word)
//  PCI_ABORT       in   1  target/master abort from PCI engine (1-cycle pulse)
//  PCI_REQ         out  1  request to PCI engine
//  PCI_TACK        out  1  1-cycle pulse: first beat, starts termination block
//  BURST           out  1  current transfer is a line transfer
//  rd_ready        out  1  1-cycle pulse per read beat after the first
//  wr_ready        out  1  1-cycle pulse per write beat after the first
//  BEAT            out  $clog2(BEATS)  index of the last completed beat
//  BUSY            out  1  transfer in progress; new TS ignored
//  BUS_ERR         out  1  1-cycle pulse on timeout/abort (feeds TEA logic)
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; watchdog = 0. Applies mid-transfer on the next edge.
//  Data event (DEV) = PCI_DATA_VLD if latched RnW = 1, else PCI_DATA_TAKEN.
//  Opposite-direction strobes are ignored.
//  IDLE: TS & PCI_HIT -> latch RnW and lburst = (SIZ == 2'b11). Set PCI_REQ = 1, BUSY = 1.
//    Go to REQ. TS & !PCI_HIT -> no action.
//  REQ: PCI_GNT -> FIRST.
//  FIRST: DEV -> PCI_TACK = 1 for one cycle, BURST = lburst (same edge), BEAT = 0.
//    If lburst, go to BEATS; else drop PCI_REQ and go to RECOV.
//  BEATS: each DEV -> one-cycle rd_ready (read) or wr_ready (write), BEAT += 1.
//    On the DEV that makes BEAT == BEATS-1: drop PCI_REQ and go to RECOV.
//    The ready strobes are never held for two consecutive cycles without a new DEV.
//  RECOV: fixed 2 cycles, matching the termination block's negate and disable phases.
//    Then clear BURST, BUSY and BEAT and go to IDLE. TS is accepted again from IDLE only.
//  Latency: DEV at edge n -> PCI_TACK or ready high after edge n+1; termination samples at
//    the falling edge that follows.
//  Watchdog: counts in REQ, FIRST and BEATS. It clears on entry to those states and on each DEV.
//    The fault condition is watchdog == TIMEOUT or PCI_ABORT.
//  Fault in REQ or FIRST: termination block not started. Pulse BUS_ERR, drop PCI_REQ,
//    go to IDLE directly with no RECOV.
//  Fault in BEATS: pulse BUS_ERR and drop PCI_REQ. Issue the remaining ready pulses on
//    consecutive alternate cycles (1 high, 1 low) to unwind the termination block. Then RECOV.
//  Simultaneous DEV and fault: DEV wins, the beat completes and the watchdog clears.
//    PCI_ABORT in the same cycle as the final DEV is ignored.
//  TS while BUSY: ignored, not queued.
//  BEAT wraps only through IDLE and never exceeds BEATS-1.
// STRUCTURE
//  Package u109_pkg:
//    - FSM state localparams IDLE/REQ/FIRST/BEATS/RECOV/UNWIND
//    - SIZ_LINE = 2'b11
//    - RECOV_CYCLES = 2
//  Sub-module u109_watchdog (TMO_W, TIMEOUT): inputs clr and en; output expired. Synchronous
//  active-high reset on RESET. The FSM, beat counter and strobe generation stay in this module.
// TESTING
//  1. Single read: TS, RnW=1, SIZ=00, HIT, GNT, one VLD -> one PCI_TACK pulse; BURST=0;
//     no rd_ready; REQ drops; BUSY low 2 cycles after PCI_TACK.
//  2. Line write: SIZ=11, RnW=0, 4 TAKEN pulses 3 cycles apart -> PCI_TACK, then exactly
//     3 wr_ready pulses; BEAT 0..3; BURST high from PCI_TACK to IDLE.
//  3. Back-to-back DEVs on consecutive cycles during a burst -> ready pulses on consecutive
//     cycles, no dropped or merged beat.
//  4. Burst stalls after beat 1 for 255 cycles -> BUS_ERR pulse; 2 unwind ready pulses
//     alternating; RECOV; IDLE.
//  5. PCI_ABORT in FIRST -> BUS_ERR, no PCI_TACK, IDLE next cycle.
//     TS while BUSY -> ignored.
//  6. RESET asserted mid-burst at BEAT=2 -> all outputs 0 next edge.
//     Fresh TS then behaves as test 1.

Source files
------------

// File: rtl/u109_pkg.sv
// Shared constants for the U109 68040-to-PCI transfer sequencer.
package u109_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_FIRST  = 3'd2;
  localparam logic [2:0] ST_BEATS  = 3'd3;
  localparam logic [2:0] ST_RECOV  = 3'd4;
  localparam logic [2:0] ST_UNWIND = 3'd5;

  localparam logic [1:0] SIZ_LINE = 2'b11;

  localparam int unsigned RECOV_CYCLES = 2;

endpackage

// File: rtl/u109_watchdog.sv
// Saturating no-progress counter; expired is registered and asserts once the count reaches TIMEOUT.
module u109_watchdog
  import u109_pkg::*;
#(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TMO_W'(TIMEOUT))) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      expired <= (cnt_d == TMO_W'(TIMEOUT));
    end
  end

endmodule

// File: rtl/u109_pci_tack_sequencer.sv
// Sequences a 68040-to-PCI transfer and turns PCI per-word data events into the
// PCI_TACK / ready strobes consumed by the falling-edge cycle-termination block.
module u109_pci_tack_sequencer
  import u109_pkg::*;
#(
  parameter int unsigned BEATS   = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TMO_W   = 8
) (
  input  logic                       CLK40,
  input  logic                       RESET,
  input  logic                       TS,
  input  logic                       RnW,
  input  logic [1:0]                 SIZ,
  input  logic                       PCI_HIT,
  input  logic                       PCI_GNT,
  input  logic                       PCI_DATA_VLD,
  input  logic                       PCI_DATA_TAKEN,
  input  logic                       PCI_ABORT,
  output logic                       PCI_REQ,
  output logic                       PCI_TACK,
  output logic                       BURST,
  output logic                       rd_ready,
  output logic                       wr_ready,
  output logic [$clog2(BEATS)-1:0]   BEAT,
  output logic                       BUSY,
  output logic                       BUS_ERR
);

  localparam int unsigned BW   = $clog2(BEATS);
  localparam int unsigned RC_W = $clog2(RECOV_CYCLES);

  logic [2:0]      state_q, state_d;
  logic            rnw_q, rnw_d;
  logic            lburst_q, lburst_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;

  logic          req_d, tack_d, burst_d, rd_d, wr_d, busy_d, err_d;
  logic [BW-1:0] beat_d;

  logic          dev_c;
  logic          fault_c;
  logic          last_c;
  logic [BW-1:0] beat_inc_c;
  logic          wd_clr_c;
  logic          wd_en_c;
  logic          wd_expired;

  // Only the strobe matching the latched direction counts as progress.
  assign dev_c      = rnw_q ? PCI_DATA_VLD : PCI_DATA_TAKEN;
  assign fault_c    = wd_expired | PCI_ABORT;
  assign beat_inc_c = BEAT + BW'(1);
  assign last_c     = (beat_inc_c == BW'(BEATS - 1));

  u109_watchdog #(
    .TMO_W   (TMO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (CLK40),
    .reset   (RESET),
    .clr     (wd_clr_c),
    .en      (wd_en_c),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    rnw_d    = rnw_q;
    lburst_d = lburst_q;
    rcnt_d   = rcnt_q;
    req_d    = PCI_REQ;
    tack_d   = 1'b0;
    burst_d  = BURST;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    beat_d   = BEAT;
    busy_d   = BUSY;
    err_d    = 1'b0;
    wd_clr_c = 1'b0;
    wd_en_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (TS && PCI_HIT) begin
          rnw_d    = RnW;
          lburst_d = (SIZ == SIZ_LINE);
          req_d    = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        wd_en_c = 1'b1;
        if (fault_c) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (PCI_GNT) begin
          state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        wd_en_c = 1'b1;
        if (dev_c) begin
          wd_clr_c = 1'b1;
          tack_d   = 1'b1;
          burst_d  = lburst_q;
          beat_d   = '0;
          if (lburst_q) begin
            state_d = ST_BEATS;
          end else begin
            req_d   = 1'b0;
            rcnt_d  = '0;
            state_d = ST_RECOV;
          end
        end else if (fault_c) begin
          // Termination block never started, so no recovery phase is needed.
          err_d   = 1'b1;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_BEATS: begin
        wd_en_c = 1'b1;
        if (dev_c) begin
          wd_clr_c = 1'b1;
          rd_d     = rnw_q;
          wr_d     = ~rnw_q;
          beat_d   = beat_inc_c;
          if (last_c) begin
            req_d   = 1'b0;
            rcnt_d  = '0;
            state_d = ST_RECOV;
          end
        end else if (fault_c) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = ST_UNWIND;
        end
      end
      ST_UNWIND: begin
        // Alternate high/low so the termination block sees each beat as distinct.
        if (!(rd_ready || wr_ready)) begin
          rd_d   = rnw_q;
          wr_d   = ~rnw_q;
          beat_d = beat_inc_c;
          if (last_c) begin
            rcnt_d  = '0;
            state_d = ST_RECOV;
          end
        end
      end
      ST_RECOV: begin
        if (rcnt_q == RC_W'(RECOV_CYCLES - 1)) begin
          burst_d = 1'b0;
          busy_d  = 1'b0;
          beat_d  = '0;
          state_d = ST_IDLE;
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      wd_clr_c = 1'b1;
    end
  end

  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      rnw_q    <= 1'b0;
      lburst_q <= 1'b0;
      rcnt_q   <= '0;
      PCI_REQ  <= 1'b0;
      PCI_TACK <= 1'b0;
      BURST    <= 1'b0;
      rd_ready <= 1'b0;
      wr_ready <= 1'b0;
      BEAT     <= '0;
      BUSY     <= 1'b0;
      BUS_ERR  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnw_q    <= rnw_d;
      lburst_q <= lburst_d;
      rcnt_q   <= rcnt_d;
      PCI_REQ  <= req_d;
      PCI_TACK <= tack_d;
      BURST    <= burst_d;
      rd_ready <= rd_d;
      wr_ready <= wr_d;
      BEAT     <= beat_d;
      BUSY     <= busy_d;
      BUS_ERR  <= err_d;
    end
  end

endmodule

// File: tb/tb_u109_pci_tack_sequencer.sv
// Directed bench for u109_pci_tack_sequencer: single/line transfers, stall timeout, abort, reset.
`timescale 1ns/1ps
module tb_u109_pci_tack_sequencer;

  logic       CLK40 = 1'b0;
  logic       RESET = 1'b1;
  logic       TS = 1'b0;
  logic       RnW = 1'b0;
  logic [1:0] SIZ = 2'b00;
  logic       PCI_HIT = 1'b0;
  logic       PCI_GNT = 1'b0;
  logic       PCI_DATA_VLD = 1'b0;
  logic       PCI_DATA_TAKEN = 1'b0;
  logic       PCI_ABORT = 1'b0;
  logic       PCI_REQ, PCI_TACK, BURST, rd_ready, wr_ready, BUSY, BUS_ERR;
  logic [1:0] BEAT;

  int checks = 0;
  int errors = 0;
  int n_tack = 0;
  int n_rd   = 0;
  int n_wr   = 0;

  u109_pci_tack_sequencer #(
    .BEATS   (4),
    .TIMEOUT (255),
    .TMO_W   (8)
  ) dut (
    .CLK40          (CLK40),
    .RESET          (RESET),
    .TS             (TS),
    .RnW            (RnW),
    .SIZ            (SIZ),
    .PCI_HIT        (PCI_HIT),
    .PCI_GNT        (PCI_GNT),
    .PCI_DATA_VLD   (PCI_DATA_VLD),
    .PCI_DATA_TAKEN (PCI_DATA_TAKEN),
    .PCI_ABORT      (PCI_ABORT),
    .PCI_REQ        (PCI_REQ),
    .PCI_TACK       (PCI_TACK),
    .BURST          (BURST),
    .rd_ready       (rd_ready),
    .wr_ready       (wr_ready),
    .BEAT           (BEAT),
    .BUSY           (BUSY),
    .BUS_ERR        (BUS_ERR)
  );

  always #5 CLK40 = ~CLK40;

  // Pulse counters sampled mid-cycle, where the termination block would look.
  always @(negedge CLK40) begin
    if (PCI_TACK) n_tack++;
    if (rd_ready) n_rd++;
    if (wr_ready) n_wr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK40);
    #1;
  endtask

  task automatic start(input logic rnw, input logic [1:0] siz);
    TS = 1'b1; RnW = rnw; SIZ = siz; PCI_HIT = 1'b1;
    step();
    TS = 1'b0; PCI_HIT = 1'b0; RnW = 1'b0; SIZ = 2'b00;
  endtask

  task automatic grant();
    PCI_GNT = 1'b1;
    step();
    PCI_GNT = 1'b0;
  endtask

  task automatic dev(input logic rnw);
    if (rnw) PCI_DATA_VLD = 1'b1;
    else     PCI_DATA_TAKEN = 1'b1;
    step();
    PCI_DATA_VLD = 1'b0;
    PCI_DATA_TAKEN = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return 32'({PCI_REQ, PCI_TACK, BURST, rd_ready, wr_ready, BEAT, BUSY, BUS_ERR});
  endfunction

  task automatic single_read(input string sfx);
    int rd0;
    rd0 = n_rd;
    start(1'b1, 2'b00);
    check({"sr_req_busy", sfx}, 32'({PCI_REQ, BUSY}), 32'h3);
    grant();
    dev(1'b1);
    check({"sr_tack", sfx}, 32'(PCI_TACK), 32'd1);
    check({"sr_burst", sfx}, 32'(BURST), 32'd0);
    check({"sr_req_drop", sfx}, 32'(PCI_REQ), 32'd0);
    step();
    check({"sr_busy_recov", sfx}, 32'({BUSY, PCI_TACK}), 32'h2);
    step();
    check({"sr_busy_low", sfx}, 32'(BUSY), 32'd0);
    check({"sr_no_rd_ready", sfx}, 32'(n_rd - rd0), 32'd0);
  endtask

  initial begin
    int tack0, rd0, wr0, k;
    logic seen;
    logic [2:0] pat;

    step();
    step();
    check("reset_outputs", outs(), 32'd0);
    RESET = 1'b0;
    step();

    // Test 1: single read
    tack0 = n_tack;
    single_read("_t1");
    check("t1_tack_count", 32'(n_tack - tack0), 32'd1);

    // Test 2: line write, words three cycles apart, stray read strobe in a gap
    tack0 = n_tack; wr0 = n_wr;
    start(1'b0, 2'b11);
    grant();
    for (int i = 0; i < 4; i++) begin
      dev(1'b0);
      if (i == 0) begin
        check("t2_tack", 32'(PCI_TACK), 32'd1);
        check("t2_burst_at_tack", 32'(BURST), 32'd1);
      end else begin
        check("t2_wr_ready", 32'(wr_ready), 32'd1);
      end
      check("t2_beat", 32'(BEAT), 32'(i));
      if (i == 1) PCI_DATA_VLD = 1'b1;
      step();
      PCI_DATA_VLD = 1'b0;
      check("t2_gap_quiet", 32'({wr_ready, rd_ready, PCI_TACK}), 32'd0);
      if (i < 3) check("t2_burst_hold", 32'(BURST), 32'd1);
      step();
    end
    check("t2_idle", 32'({PCI_REQ, BURST, BUSY, BEAT}), 32'd0);
    check("t2_wr_count", 32'(n_wr - wr0), 32'd3);
    check("t2_tack_count", 32'(n_tack - tack0), 32'd1);

    // Test 3: read burst with back-to-back data events
    rd0 = n_rd;
    start(1'b1, 2'b11);
    grant();
    PCI_DATA_VLD = 1'b1;
    step();
    check("t3_tack", 32'({PCI_TACK, rd_ready}), 32'h2);
    for (int i = 1; i < 4; i++) begin
      step();
      check("t3_rd_ready", 32'({PCI_TACK, rd_ready}), 32'h1);
      check("t3_beat", 32'(BEAT), 32'(i));
    end
    PCI_DATA_VLD = 1'b0;
    step();
    step();
    check("t3_idle", 32'({BUSY, BURST, rd_ready}), 32'd0);
    check("t3_rd_count", 32'(n_rd - rd0), 32'd3);

    // Test 4: burst stalls after beat 1, watchdog unwinds
    rd0 = n_rd;
    start(1'b1, 2'b11);
    grant();
    dev(1'b1);
    dev(1'b1);
    check("t4_beat1", 32'(BEAT), 32'd1);
    seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 300 && !seen; i++) begin
      step();
      if (BUS_ERR) begin
        seen = 1'b1;
        k = i;
      end else if (!PCI_REQ) begin
        check("t4_req_held", 32'(PCI_REQ), 32'd1);
      end
    end
    check("t4_bus_err_seen", 32'(seen), 32'd1);
    check("t4_bus_err_window", 32'((k >= 255) && (k <= 257)), 32'd1);
    check("t4_req_drop", 32'(PCI_REQ), 32'd0);
    pat = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      pat[2-i] = rd_ready;
    end
    check("t4_unwind_pattern", 32'(pat), 32'h5);
    check("t4_unwind_beat", 32'(BEAT), 32'd3);
    step();
    check("t4_recov_busy", 32'(BUSY), 32'd1);
    step();
    check("t4_idle", 32'({BUSY, BURST, BEAT}), 32'd0);
    check("t4_rd_count", 32'(n_rd - rd0), 32'd3);

    // Test 5: abort in FIRST, TS while busy, TS without hit
    tack0 = n_tack;
    start(1'b1, 2'b00);
    grant();
    PCI_ABORT = 1'b1;
    step();
    PCI_ABORT = 1'b0;
    check("t5_abort_err", 32'({BUS_ERR, BUSY, PCI_REQ, PCI_TACK}), 32'h8);
    step();
    check("t5_err_pulse", 32'(BUS_ERR), 32'd0);
    check("t5_no_tack", 32'(n_tack - tack0), 32'd0);

    start(1'b1, 2'b00);
    TS = 1'b1; RnW = 1'b0; SIZ = 2'b11; PCI_HIT = 1'b1;
    step();
    TS = 1'b0; PCI_HIT = 1'b0; SIZ = 2'b00;
    grant();
    dev(1'b1);
    check("t5_busy_ts_ignored", 32'({PCI_TACK, BURST}), 32'h2);
    step();
    step();
    step();
    check("t5_not_queued", 32'({PCI_REQ, BUSY}), 32'd0);
    TS = 1'b1; RnW = 1'b1; PCI_HIT = 1'b0;
    step();
    TS = 1'b0;
    check("t5_no_hit", 32'({PCI_REQ, BUSY}), 32'd0);

    // Test 6: reset mid-burst at BEAT=2, then a fresh single read
    start(1'b0, 2'b11);
    grant();
    dev(1'b0);
    dev(1'b0);
    dev(1'b0);
    check("t6_beat2", 32'(BEAT), 32'd2);
    RESET = 1'b1;
    step();
    check("t6_reset_outputs", outs(), 32'd0);
    RESET = 1'b0;
    step();
    single_read("_t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
